// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data RAM arbiter.
// The default widths are shared with the CPU top.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    // Bit positions within the grant vector produced by mem_arb_pick.
    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters.
// Also holds the streak counter that bounds how long fetch can starve.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic       clk,
    input  logic       init,
    input  logic       if_req,
    input  logic       d_req,
    input  state_t     state,
    output logic [1:0] gnt
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                fetch_turn;

    assign fetch_turn = if_req && (streak_q == STREAK_MAX);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt = '0;
        if (!init && (state == ST_IDLE)) begin
            if (d_req && !fetch_turn) begin
                gnt[GNT_D] = 1'b1;
            end else if (if_req) begin
                gnt[GNT_IF] = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (gnt[GNT_D] && if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
        end else if (gnt != '0) begin
            streak_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (init) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and load/store traffic.
// Each access runs IDLE -> ISSUE -> WAIT (RAM_LATENCY cycles) -> completion pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_STREAK  = 4
) (
    input  logic              clk,
    input  logic              init,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic [1:0]        gnt;
    logic              grant;
    logic              last_wait;

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .clk    (clk),
        .init   (init),
        .if_req (if_req),
        .d_req  (d_req),
        .state  (state_q),
        .gnt    (gnt)
    );

    assign grant     = |gnt;
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts down the remaining WAIT cycles; zero marks the sampling cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_LAST;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_wait;
            if (grant) begin
                owner_q <= gnt[GNT_D] ? OWN_D : OWN_IF;
                we_q    <= gnt[GNT_D] && d_we;
                addr_q  <= gnt[GNT_D] ? d_addr : if_addr;
                wdata_q <= gnt[GNT_D] ? d_wdata : '0;
            end
            if (last_wait && !we_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        if_gnt    = gnt[GNT_IF];
        d_gnt     = gnt[GNT_D];
        ram_en    = (state_q == ST_ISSUE);
        ram_we    = (state_q == ST_ISSUE) && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if_rvalid = done_q && (owner_q == OWN_IF);
        d_done    = done_q && (owner_q == OWN_D);
        if_rdata  = rdata_q;
        d_rdata   = rdata_q;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port 16-bit data RAM between the instruction fetch port and the load/store data port of the pipelined CPU. Each requester gets a request/grant handshake and a one-cycle completion pulse. The arbiter drives the RAM port and counts a fixed RAM read latency. Data accesses have priority, and a streak limit guarantees forward progress for fetch. The block sits between the fetch/memory stages and the RAM, replacing the direct fetch-to-instruction-memory and data-to-RAM connections.

## Interface
- DATA_W, 16: data width.
- ADDR_W, 16: address width.
- RAM_LATENCY, 2: cycles from ram_en to valid ram_rdata; must be at least 1.
- MAX_STREAK, 4: consecutive data grants allowed while fetch waits; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- init  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch read request; hold if_req and if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; hold d_req, d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_done  out  1  one-cycle pulse: data access complete; d_rdata valid if it was a read.
- d_rdata  out  DATA_W  data read result.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; high only together with ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

## Operation
**States:**
- IDLE: grants are issued only in this state.
- ISSUE: lasts exactly 1 cycle; ram_en = 1.
- WAIT: lasts RAM_LATENCY cycles.

**Grant logic (IDLE only):**
- if_gnt and d_gnt are combinational and mutually exclusive.
- Only one requester active: grant it.
- Both active: grant data, unless streak == MAX_STREAK, in which case grant fetch.

**On a grant edge:**
- Capture owner, we, addr and wdata.
- Go to ISSUE.
- Requester may change or drop its request after the grant; the captured transaction is unaffected.

**Streak counter:**
- Width is clog2(MAX_STREAK+1).
- Increments (saturating) on a data grant while if_req = 1.
- Clears on a fetch grant, or on a data grant while if_req = 0.

**ISSUE → WAIT.** WAIT counts down RAM_LATENCY cycles. In the last WAIT cycle, ram_rdata is captured into a shared rdata register, but only if the transaction is a read. The state then returns to IDLE.

**Completion pulse:** in the first IDLE cycle after WAIT, exactly one of the following is high:
- if_rvalid, for a fetch owner.
- d_done, for a data owner, read or write.

**Data outputs:**
- if_rdata and d_rdata are both driven from the shared rdata register.
- Writes leave the register unchanged.
- The register holds its value until the next read completes.

**RAM port:** ram_addr and ram_wdata hold the captured values until the next capture.

**Reset:**
- Reset values: state = IDLE, streak = 0, rdata = 0, captured regs = 0.
- All outputs read 0 in and after reset, until a new grant.
- Reset mid-ISSUE or mid-WAIT aborts the access: no completion pulse, and ram_en = 0 from the next cycle.
- No grant is issued while init = 1.

## Timing
- Let the grant cycle be G.
- ram_en and ram_we are high in cycle G+1 only.
- ram_rdata is sampled at the end of cycle G+1+RAM_LATENCY.
- The completion pulse occurs in cycle G+RAM_LATENCY+2.
- A new grant may occur in the completion cycle itself.
- Throughput: one access per RAM_LATENCY+2 cycles.
- Requests arriving during ISSUE or WAIT wait for IDLE; no queueing beyond the hold rule.

## Structure
- Package mem_arb_pkg contains:
  - State enum: ST_IDLE, ST_ISSUE, ST_WAIT.
  - Owner enum: OWN_IF, OWN_D.
  - Default DATA_W and ADDR_W constants shared with the CPU top.
- One sub-module, mem_arb_pick: grant selection logic plus the streak counter. It takes if_req, d_req, state and the grant edge, and outputs the grant vector.
- Latency counter and FSM stay in mem_arbiter.

## Test plan
- **Reset:** init = 1 for 2 cycles with if_req = d_req = 1 → no grants, ram_en = 0, all outputs 0; the first grant (d_gnt) appears in the cycle after init falls.
- **Fetch read:** RAM_LATENCY = 2, if_addr = 0x0010, RAM returns 0xBEEF → if_gnt at G; ram_en = 1 and ram_addr = 0x0010 at G+1; if_rvalid = 1 with if_rdata = 0xBEEF at G+4.
- **Data write:** d_addr = 0x0020, d_wdata = 0x1234 → ram_we = ram_en = 1 at G+1; d_done at G+4; if_rvalid stays 0; d_rdata unchanged.
- **Starvation guard:** both requests held high, MAX_STREAK = 4 → grant order D,D,D,D,IF,D,D,D,D,IF; consecutive grants spaced exactly 4 cycles apart.
- **Abort:** init asserted in the second WAIT cycle of a data read → no d_done, ram_en stays 0, state IDLE; after init falls, a new read completes normally.
- **Drop after grant:** d_req dropped at G+1 and d_addr changed → RAM still sees the captured address; d_done at G+4.
